matrix_scroll_ctrl: RTL

- Parametrised LED dot-matrix scroll controller. Drives a ROWS x COLS multiplexed matrix from a writable pattern buffer of DEPTH rows.
- Scrolls the visible window up or down at a programmable rate, with pause, tear-free frame-aligned updates and a wrap pulse.
- Sits between the board top level (matrix column/row pins) and any pattern-loading logic.
- Fully single-clock: no derived clocks.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_row_scanner.sv | 46 ++++
 rtl/matrix_scroll_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_pkg: shared constants and helpers for the LED matrix scroll controller
// Revision: 1.0
// ----------------------------------------------------------------------------
package matrix_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam int   SEG_MAX_W = 64;

  // Blank column pattern; callers size-cast the result down to COLS bits.
  function automatic logic [SEG_MAX_W-1:0] seg_blank(input int cols);
    logic [SEG_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SEG_MAX_W; i++) begin
      if (i < cols) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Single conditional subtract: valid while a, b < depth.
  function automatic int unsigned mod_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned depth);
    int unsigned s;
    s = a + b;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_row_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_row_scanner: per-row dwell prescaler and row counter with frame marker
// Revision: 1.0
// ----------------------------------------------------------------------------
module matrix_row_scanner
  import matrix_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int SCAN_SHIFT = 13,
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] scanout,
  output logic             row_adv,
  output logic             frame_end
);

  logic [SCAN_SHIFT-1:0] presc_q, presc_d;
  logic [ROW_W-1:0]      row_q, row_d;

  always_comb begin
    row_adv   = (presc_q == '1);
    frame_end = row_adv && (row_q == ROW_W'(ROWS - 1));
    presc_d   = presc_q + SCAN_SHIFT'(1);
    row_d     = row_q;
    if (row_adv) begin
      row_d = frame_end ? '0 : row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      row_q   <= '0;
    end else begin
      presc_q <= presc_d;
      row_q   <= row_d;
    end
  end

  assign scanout = row_q;

endmodule
`default_nettype wire

// File: rtl/matrix_scroll_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_scroll_ctrl: scrolling LED dot-matrix driver with frame-aligned updates
// Revision: 1.0
// ----------------------------------------------------------------------------
module matrix_scroll_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DEPTH      = 16,
  parameter int SCAN_SHIFT = 13,
  parameter int STEP_DIV   = 12500000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     scroll_en,
  input  logic                     dir,
  output logic [COLS-1:0]          segout,
  output logic [$clog2(ROWS)-1:0]  scanout,
  output logic [$clog2(DEPTH)-1:0] offset,
  output logic                     wrap
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int TICK_W = $clog2(STEP_DIV);
  localparam logic [COLS-1:0] SEG_BLANK = COLS'(seg_blank(COLS));

  logic [COLS-1:0]   pat_q [DEPTH];
  logic [COLS-1:0]   pat_d [DEPTH];
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [COLS-1:0]   segout_q, segout_d;
  logic              wrap_q, wrap_d;

  logic              row_adv;
  logic              frame_end;
  logic              tick_tc;
  logic              step_req;
  logic              step_now;
  logic [ROW_W-1:0]  row_nxt;
  logic [ADDR_W-1:0] fetch_idx;

  matrix_row_scanner #(
    .ROWS       (ROWS),
    .SCAN_SHIFT (SCAN_SHIFT)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .scanout   (scanout),
    .row_adv   (row_adv),
    .frame_end (frame_end)
  );

  always_comb begin
    tick_tc   = (tick_q == TICK_W'(STEP_DIV - 1));
    tick_d    = tick_tc ? '0 : tick_q + TICK_W'(1);
    // A tick landing on the frame boundary is consumed on that same edge.
    step_req  = pending_q || (tick_tc && scroll_en);
    step_now  = frame_end && step_req;
    pending_d = frame_end ? 1'b0 : step_req;

    offset_d = offset_q;
    wrap_d   = 1'b0;
    if (step_now) begin
      if (dir == DIR_UP) begin
        if (offset_q == ADDR_W'(DEPTH - 1)) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + ADDR_W'(1);
        end
      end else begin
        if (offset_q == '0) begin
          offset_d = ADDR_W'(DEPTH - 1);
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q - ADDR_W'(1);
        end
      end
    end

    // Fetch for the row being entered, using the offset that frame will show.
    row_nxt   = frame_end ? '0 : scanout + ROW_W'(1);
    fetch_idx = ADDR_W'(mod_add(32'(offset_d), 32'(row_nxt), 32'(DEPTH)));
    segout_d  = row_adv ? pat_q[fetch_idx] : segout_q;

    pat_d = pat_q;
    if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
      pat_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q     <= '{default: SEG_BLANK};
      tick_q    <= '0;
      pending_q <= 1'b0;
      offset_q  <= '0;
      segout_q  <= SEG_BLANK;
      wrap_q    <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      offset_q  <= offset_d;
      segout_q  <= segout_d;
      wrap_q    <= wrap_d;
    end
  end

  assign segout = segout_q;
  assign offset = offset_q;
  assign wrap   = wrap_q;

endmodule
`default_nettype wire
